// File: rtl/byte_register_load_controller.sv
`default_nettype none
// ============================================================================
//  Module   : byte_register_load_controller
//  Purpose  : Sequences a byte_write_register. Bytes arriving on a valid/ready
//             handshake are steered into consecutive byte lanes (lane 0
//             first). Once every lane has been written the assembled word is
//             flagged with WORD_VALID and input is stalled until the consumer
//             acknowledges it with WORD_READY.
//  Ports    :
//    CLK             in   rising-edge clock
//    ARESET          in   asynchronous active-low reset
//    IN_VALID        in   input byte valid
//    IN_DATA         in   input byte
//    IN_READY        out  controller accepts IN_DATA this cycle
//    CLEAR           in   synchronous abort of the partial or held word
//    REG_ENABLE      out  byte_write_register ENABLE
//    REG_BYTE_NUM    out  byte_write_register BYTE_NUM (lane index)
//    REG_INPUT_VALUE out  byte_write_register INPUT_VALUE
//    WORD_VALID      out  all lanes written, register output is stable
//    WORD_READY      in   consumer takes the word
//    BUSY            out  at least one lane of the current word is written
//    WORDS_DONE      out  count of acknowledged words (wraps 255 -> 0)
//  Revision : 1.0  initial release
// ============================================================================
module byte_register_load_controller #(
    parameter int SIZE_IN_BYTES = 13,
    parameter int BYTE_NUM_SIZE = 4
) (
    input  logic                     CLK,
    input  logic                     ARESET,
    input  logic                     IN_VALID,
    input  logic [7:0]               IN_DATA,
    output logic                     IN_READY,
    input  logic                     CLEAR,
    output logic                     REG_ENABLE,
    output logic [BYTE_NUM_SIZE-1:0] REG_BYTE_NUM,
    output logic [7:0]               REG_INPUT_VALUE,
    output logic                     WORD_VALID,
    input  logic                     WORD_READY,
    output logic                     BUSY,
    output logic [7:0]               WORDS_DONE
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity: the lane index must be able to
    // address every lane, and a single-lane word makes no sense here.
    // ------------------------------------------------------------------------
    generate
        if ((SIZE_IN_BYTES < 2) || (SIZE_IN_BYTES > (2 ** BYTE_NUM_SIZE))) begin : g_param_check
            $error("byte_register_load_controller: SIZE_IN_BYTES must be >= 2 and <= 2**BYTE_NUM_SIZE");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_st_fill = 1'b0;  // collecting lanes
    localparam logic [0:0] c_st_hold = 1'b1;  // word complete, waiting for ack

    localparam logic [BYTE_NUM_SIZE-1:0] c_last_lane = BYTE_NUM_SIZE'(SIZE_IN_BYTES - 1);
    localparam logic [BYTE_NUM_SIZE-1:0] c_lane_one  = BYTE_NUM_SIZE'(1);

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic [0:0]               r_state;
    logic [BYTE_NUM_SIZE-1:0] r_idx;
    logic                     r_word_valid;
    logic                     r_busy;
    logic [7:0]               r_words_done;

    logic [0:0]               w_state_next;
    logic [BYTE_NUM_SIZE-1:0] w_idx_next;
    logic                     w_word_valid_next;
    logic                     w_busy_next;
    logic [7:0]               w_words_done_next;

    logic                     w_in_ready;
    logic                     w_accept;

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ARESET) begin
        if (!ARESET) begin
            r_state      <= c_st_fill;
            r_idx        <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_words_done <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_word_valid <= w_word_valid_next;
            r_busy       <= w_busy_next;
            r_words_done <= w_words_done_next;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic. CLEAR overrides everything, including an
    // acknowledge in the same cycle, so the word counter only advances on a
    // genuine hand-over of a complete word.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_word_valid_next = r_word_valid;
        w_busy_next       = r_busy;
        w_words_done_next = r_words_done;

        if (CLEAR) begin
            w_state_next      = c_st_fill;
            w_idx_next        = '0;
            w_word_valid_next = 1'b0;
            w_busy_next       = 1'b0;
        end else begin
            case (r_state)
                c_st_fill: begin
                    if (w_accept) begin
                        w_busy_next = 1'b1;
                        if (r_idx == c_last_lane) begin
                            // Last lane lands on this edge; the register shows
                            // the complete word in the same cycle WORD_VALID rises.
                            w_idx_next        = '0;
                            w_state_next      = c_st_hold;
                            w_word_valid_next = 1'b1;
                        end else begin
                            w_idx_next = r_idx + c_lane_one;
                        end
                    end
                end
                c_st_hold: begin
                    if (r_word_valid && WORD_READY) begin
                        w_state_next      = c_st_fill;
                        w_word_valid_next = 1'b0;
                        w_busy_next       = 1'b0;
                        w_words_done_next = r_words_done + 8'd1;
                    end
                end
                default: begin
                    w_state_next      = c_st_fill;
                    w_idx_next        = '0;
                    w_word_valid_next = 1'b0;
                    w_busy_next       = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs. The register write is the handshake itself, so
    // there is no latency between accept and lane write. Input is refused
    // for the whole of HOLD, including the acknowledge cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_ready      = (r_state == c_st_fill) && !CLEAR;
        w_accept        = IN_VALID && w_in_ready;

        IN_READY        = w_in_ready;
        REG_ENABLE      = w_accept;
        REG_BYTE_NUM    = r_idx;
        REG_INPUT_VALUE = IN_DATA;
        WORD_VALID      = r_word_valid;
        BUSY            = r_busy;
        WORDS_DONE      = r_words_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_register_load_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_register_load_controller
//  Purpose  : Self-checking bench for byte_register_load_controller. A
//             behavioural model (queue of accepted bytes, hold flag, word
//             counter) predicts every output each cycle; a bench-side byte
//             register captures the lane writes so assembled words can be
//             compared against the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_byte_register_load_controller;

    localparam int N  = 13;
    localparam int BN = 4;

    logic          CLK = 1'b0;
    logic          ARESET;
    logic          IN_VALID;
    logic [7:0]    IN_DATA;
    logic          IN_READY;
    logic          CLEAR;
    logic          REG_ENABLE;
    logic [BN-1:0] REG_BYTE_NUM;
    logic [7:0]    REG_INPUT_VALUE;
    logic          WORD_VALID;
    logic          WORD_READY;
    logic          BUSY;
    logic [7:0]    WORDS_DONE;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    byte_register_load_controller #(
        .SIZE_IN_BYTES (N),
        .BYTE_NUM_SIZE (BN)
    ) dut (
        .CLK             (CLK),
        .ARESET          (ARESET),
        .IN_VALID        (IN_VALID),
        .IN_DATA         (IN_DATA),
        .IN_READY        (IN_READY),
        .CLEAR           (CLEAR),
        .REG_ENABLE      (REG_ENABLE),
        .REG_BYTE_NUM    (REG_BYTE_NUM),
        .REG_INPUT_VALUE (REG_INPUT_VALUE),
        .WORD_VALID      (WORD_VALID),
        .WORD_READY      (WORD_READY),
        .BUSY            (BUSY),
        .WORDS_DONE      (WORDS_DONE)
    );

    // Bench-side byte_write_register driven by the controller.
    logic [8*N-1:0] reg_q = '0;
    always @(posedge CLK)
        if (ARESET && REG_ENABLE && (int'(REG_BYTE_NUM) < N))
            reg_q[int'(REG_BYTE_NUM)*8 +: 8] <= REG_INPUT_VALUE;

    // ------------------------------------------------------------------------
    // Reference model: bytes of the word in progress, whether a finished
    // word is waiting for its acknowledge, and the acknowledged-word count.
    // ------------------------------------------------------------------------
    logic [7:0]     cur[$];
    bit             holding  = 1'b0;
    int             done     = 0;
    logic [8*N-1:0] exp_word = '0;
    bit             word_evt = 1'b0;

    task automatic model_edge();
        word_evt = 1'b0;
        if (CLEAR) begin
            cur.delete();
            holding = 1'b0;
        end else if (holding) begin
            if (WORD_READY) begin
                holding = 1'b0;
                done    = (done + 1) % 256;
            end
        end else if (IN_VALID) begin
            cur.push_back(IN_DATA);
            if (cur.size() == N) begin
                for (int i = 0; i < N; i++) exp_word[8*i +: 8] = cur[i];
                cur.delete();
                holding  = 1'b1;
                word_evt = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        cur.delete();
        holding  = 1'b0;
        done     = 0;
        word_evt = 1'b0;
    endtask

    // {IN_READY, REG_ENABLE, REG_BYTE_NUM, REG_INPUT_VALUE, WORD_VALID, BUSY, WORDS_DONE}
    function automatic logic [23:0] exp_vec();
        logic       rdy;
        logic [3:0] lane;
        rdy  = !holding && !CLEAR;
        lane = 4'(cur.size());
        return {rdy, IN_VALID && rdy, lane, IN_DATA, logic'(holding),
                logic'(holding || (cur.size() > 0)), 8'(done)};
    endfunction

    function automatic logic [23:0] obs_vec();
        return {IN_READY, REG_ENABLE, REG_BYTE_NUM, REG_INPUT_VALUE, WORD_VALID, BUSY, WORDS_DONE};
    endfunction

    // Stimulus is applied just after the falling edge, so outputs are
    // sampled well away from the rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic r);
        IN_VALID   = v;
        IN_DATA    = d;
        CLEAR      = c;
        WORD_READY = r;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (ARESET) model_edge();
        @(negedge CLK);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        ARESET = 1'b0;
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            vectors++;
            if ({IN_READY, REG_BYTE_NUM, WORD_VALID, BUSY, WORDS_DONE} !== {1'b1, 4'd0, 1'b0, 1'b0, 8'd0}) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got rdy=%b lane=%0d wv=%b busy=%b done=%0d, want rdy=1 lane=0 wv=0 busy=0 done=0",
                         i, IN_READY, REG_BYTE_NUM, WORD_VALID, BUSY, WORDS_DONE);
            end
        end
        @(negedge CLK);
        ARESET = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [8*N-1:0] want;
        want = 104'h0C0B0A09080706050403020100;
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if (!WORD_VALID || (reg_q !== want) || (obs_vec() !== exp_vec())) begin
            miscompares++;
            $display("FAIL back_to_back word: got wv=%b %h vec %h want wv=1 %h vec %h",
                     WORD_VALID, reg_q, obs_vec(), want, exp_vec());
        end
    endtask

    task automatic test_hold();
        logic [8*N-1:0] held;
        held = reg_q;
        for (int i = 0; i < 7; i++) begin
            // five stalled cycles, one acknowledge, then the next lane 0
            drive(1'b1, (i == 6) ? 8'h77 : 8'hFF, 1'b0, (i == 5));
            #1;
            vectors++;
            if ((obs_vec() !== exp_vec()) || ((i < 6) && (reg_q !== held))) begin
                miscompares++;
                $display("FAIL hold cyc %0d: got %h reg %h want %h reg %h", i, obs_vec(), reg_q, exp_vec(), held);
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL hold clear: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_gaps();
        int b;
        b = 0;
        for (int i = 0; i < 2*N + 2; i++) begin
            if (i == 2*N + 1) drive(1'b0, 8'h00, 1'b0, 1'b1);
            else if (i % 2 == 1 || b >= N) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
            else begin
                drive(1'b1, 8'(b), 1'b0, 1'b0);
                b++;
            end
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL gaps cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
            if (word_evt) begin
                vectors++;
                if (reg_q !== exp_word) begin
                    miscompares++;
                    $display("FAIL gaps word: got %h want %h", reg_q, exp_word);
                end
            end
        end
    endtask

    task automatic test_clear_mid();
        for (int i = 0; i < 6 + 1 + N + 1; i++) begin
            if (i < 6)           drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            else if (i == 6)     drive(1'b1, 8'h99, 1'b1, 1'b0);
            else if (i < 7 + N)  drive(1'b1, 8'(8'hA0 + (i - 7)), 1'b0, 1'b0);
            else                 drive(1'b0, 8'h00, 1'b0, 1'b1);
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL clear_mid cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
            if (word_evt) begin
                vectors++;
                if ((reg_q !== exp_word) || (i != 6 + N)) begin
                    miscompares++;
                    $display("FAIL clear_mid word at cyc %0d: got %h want %h at cyc %0d", i, reg_q, exp_word, 6 + N);
                end
            end
        end
    endtask

    task automatic test_clear_hold();
        for (int i = 0; i < N + 2; i++) begin
            if (i < N)       drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            else if (i == N) drive(1'b0, 8'h00, 1'b1, 1'b1);
            else             drive(1'b0, 8'h00, 1'b0, 1'b1);
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL clear_hold cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL async_reset fill cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        ARESET = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({REG_BYTE_NUM, BUSY, WORD_VALID, WORDS_DONE} !== {4'd0, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL async_reset immediate: got lane=%0d busy=%b wv=%b done=%0d want lane=0 busy=0 wv=0 done=0",
                     REG_BYTE_NUM, BUSY, WORD_VALID, WORDS_DONE);
        end
        @(negedge CLK);
        ARESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 40) == 0, ($urandom % 3) == 0);
            #1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
            if (word_evt) begin
                vectors++;
                if (reg_q !== exp_word) begin
                    miscompares++;
                    $display("FAIL random word cyc %0d: got %h want %h", i, reg_q, exp_word);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] start;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        start = 8'(done);
        for (int w = 0; w < 256; w++) begin
            for (int i = 0; i <= N; i++) begin
                if (i < N) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
                else       drive(1'b0, 8'h00, 1'b0, 1'b1);
                #1;
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL wrap word %0d cyc %0d: got %h want %h", w, i, obs_vec(), exp_vec());
                end
                tick();
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if (WORDS_DONE !== start) begin
            miscompares++;
            $display("FAIL wrap count: got %0d want %0d", WORDS_DONE, start);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_gaps();
        test_clear_mid();
        test_clear_hold();
        test_async_reset();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
